// File: rtl/me_sad_search_engine_if.sv
// Signal bundle for the SAD search engine: start and current block in, column stream in,
// per-batch SAD vector and final best result out.
interface me_sad_search_engine_if #(
  parameter int unsigned PIXELS_IN_BATCH = 16,
  parameter int unsigned EDGE_LEN        = 8,
  parameter int unsigned BIT_DEPTH       = 8,
  parameter int unsigned SAD_WIDTH       = 14,
  parameter int unsigned IDX_WIDTH       = 6
);
  logic                                          start;
  logic [EDGE_LEN*EDGE_LEN*BIT_DEPTH-1:0]        cur_block;
  logic                                          col_valid;
  logic                                          col_ready;
  logic [EDGE_LEN*PIXELS_IN_BATCH*BIT_DEPTH-1:0] ref_col;
  logic                                          busy;
  logic [SAD_WIDTH*PIXELS_IN_BATCH-1:0]          sad_batch;
  logic                                          sad_batch_valid;
  logic [SAD_WIDTH-1:0]                          best_sad;
  logic [IDX_WIDTH-1:0]                          best_idx;
  logic                                          done;

  modport master (
    output start, cur_block, col_valid, ref_col,
    input  col_ready, busy, sad_batch, sad_batch_valid, best_sad, best_idx, done
  );

  modport slave (
    input  start, cur_block, col_valid, ref_col,
    output col_ready, busy, sad_batch, sad_batch_valid, best_sad, best_idx, done
  );
endinterface

// File: rtl/me_sad_search_engine.sv
// Block-matching SAD engine: streams candidate columns through a 4-stage pipeline
// (abs diff, column sum, accumulate, min search) and reports the best candidate of the window.
module me_sad_search_engine #(
  parameter int unsigned PIXELS_IN_BATCH = 16,
  parameter int unsigned EDGE_LEN        = 8,
  parameter int unsigned BIT_DEPTH       = 8,
  parameter int unsigned NUM_BATCHES     = 4,
  parameter int unsigned SAD_WIDTH       = 14,
  parameter int unsigned IDX_WIDTH       = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  me_sad_search_engine_if.slave  bus
);
  localparam int unsigned CW   = (EDGE_LEN > 1) ? $clog2(EDGE_LEN) : 1;
  localparam int unsigned BW   = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
  localparam int unsigned CSW  = BIT_DEPTH + $clog2(EDGE_LEN);
  localparam int unsigned NPIX = EDGE_LEN * EDGE_LEN;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                      r_state, w_next;
  logic [NPIX*BIT_DEPTH-1:0]   r_cur;
  logic [CW-1:0]               r_col_cnt;
  logic [BW-1:0]               r_batch_cnt;
  logic                        w_accept, w_start, w_col_last, w_batch_last;

  logic                        r_s1_vld, r_s1_bl, r_s1_wl;
  logic [BW-1:0]               r_s1_batch;
  logic [BIT_DEPTH-1:0]        r_s1_ad [EDGE_LEN][PIXELS_IN_BATCH];
  logic [BIT_DEPTH-1:0]        w_ad    [EDGE_LEN][PIXELS_IN_BATCH];

  logic                        r_s2_vld, r_s2_bl, r_s2_wl;
  logic [BW-1:0]               r_s2_batch;
  logic [CSW-1:0]              r_s2_sum [PIXELS_IN_BATCH];
  logic [CSW-1:0]              w_colsum [PIXELS_IN_BATCH];

  logic [SAD_WIDTH-1:0]        r_acc [PIXELS_IN_BATCH];
  logic                        r_s3_wl;
  logic [BW-1:0]               r_s3_batch;

  logic [SAD_WIDTH-1:0]        r_best_sad, w_min, w_new_sad;
  logic [IDX_WIDTH-1:0]        r_best_idx, w_new_idx;
  int                          w_min_k;

  logic                                 r_col_ready, r_busy, r_sbv, r_done;
  logic [SAD_WIDTH*PIXELS_IN_BATCH-1:0] r_sad_batch;
  logic [SAD_WIDTH-1:0]                 r_o_best_sad;
  logic [IDX_WIDTH-1:0]                 r_o_best_idx;

  assign w_col_last   = (r_col_cnt == CW'(EDGE_LEN - 1));
  assign w_batch_last = (r_batch_cnt == BW'(NUM_BATCHES - 1));
  assign w_start      = (r_state == S_IDLE) && bus.start;

  assign bus.col_ready       = r_col_ready;
  assign bus.busy            = r_busy;
  assign bus.sad_batch       = r_sad_batch;
  assign bus.sad_batch_valid = r_sbv;
  assign bus.best_sad        = r_o_best_sad;
  assign bus.best_idx        = r_o_best_idx;
  assign bus.done            = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state; the window completes once the last batch has passed the min stage.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN: begin
        w_accept = bus.col_valid;
        if (w_accept && w_col_last && w_batch_last) w_next = S_DRAIN;
      end
      S_DRAIN: if (r_sbv && r_s3_wl) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Absolute differences of the incoming column against current-block column col_cnt.
  always_comb begin
    logic [BIT_DEPTH-1:0] v_ref, v_cur;
    v_ref = '0;
    v_cur = '0;
    for (int r = 0; r < int'(EDGE_LEN); r++) begin
      v_cur = r_cur[(r*int'(EDGE_LEN) + int'(r_col_cnt))*int'(BIT_DEPTH) +: BIT_DEPTH];
      for (int k = 0; k < int'(PIXELS_IN_BATCH); k++) begin
        v_ref = bus.ref_col[(r*int'(PIXELS_IN_BATCH) + k)*int'(BIT_DEPTH) +: BIT_DEPTH];
        w_ad[r][k] = (v_ref > v_cur) ? (v_ref - v_cur) : (v_cur - v_ref);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < int'(PIXELS_IN_BATCH); k++) begin
      w_colsum[k] = '0;
      for (int r = 0; r < int'(EDGE_LEN); r++)
        w_colsum[k] = w_colsum[k] + CSW'(r_s1_ad[r][k]);
    end
  end

  // Lane minimum with lowest lane winning ties, then strict compare against the running best.
  always_comb begin
    w_min   = r_sad_batch[0 +: SAD_WIDTH];
    w_min_k = 0;
    for (int k = 1; k < int'(PIXELS_IN_BATCH); k++) begin
      if (r_sad_batch[k*int'(SAD_WIDTH) +: SAD_WIDTH] < w_min) begin
        w_min   = r_sad_batch[k*int'(SAD_WIDTH) +: SAD_WIDTH];
        w_min_k = k;
      end
    end
    w_new_sad = r_best_sad;
    w_new_idx = r_best_idx;
    if (w_min < r_best_sad) begin
      w_new_sad = w_min;
      w_new_idx = IDX_WIDTH'(int'(r_s3_batch)*int'(PIXELS_IN_BATCH) + w_min_k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur        <= '0;
      r_col_cnt    <= '0;
      r_batch_cnt  <= '0;
      r_best_sad   <= '0;
      r_best_idx   <= '0;
      r_col_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_o_best_sad <= '0;
      r_o_best_idx <= '0;
    end else begin
      r_col_ready <= (w_next == S_RUN);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_DONE);
      if (r_sbv) begin
        r_best_sad <= w_new_sad;
        r_best_idx <= w_new_idx;
      end
      if (w_next == S_DONE) begin
        r_o_best_sad <= w_new_sad;
        r_o_best_idx <= w_new_idx;
      end
      if (w_start) begin
        r_cur       <= bus.cur_block;
        r_col_cnt   <= '0;
        r_batch_cnt <= '0;
        r_best_sad  <= '1;
        r_best_idx  <= '0;
      end else if (w_accept) begin
        if (w_col_last) begin
          r_col_cnt   <= '0;
          r_batch_cnt <= r_batch_cnt + BW'(1);
        end else begin
          r_col_cnt   <= r_col_cnt + CW'(1);
        end
      end
    end
  end

  // S1/S2: abs-diff register and column-sum register, tags follow the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_bl    <= 1'b0;
      r_s1_wl    <= 1'b0;
      r_s1_batch <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_bl    <= 1'b0;
      r_s2_wl    <= 1'b0;
      r_s2_batch <= '0;
      for (int r = 0; r < int'(EDGE_LEN); r++)
        for (int k = 0; k < int'(PIXELS_IN_BATCH); k++) r_s1_ad[r][k] <= '0;
      for (int k = 0; k < int'(PIXELS_IN_BATCH); k++) r_s2_sum[k] <= '0;
    end else begin
      r_s1_vld   <= w_accept;
      r_s1_bl    <= w_col_last;
      r_s1_wl    <= w_col_last && w_batch_last;
      r_s1_batch <= r_batch_cnt;
      r_s1_ad    <= w_ad;
      r_s2_vld   <= r_s1_vld;
      r_s2_bl    <= r_s1_bl;
      r_s2_wl    <= r_s1_wl;
      r_s2_batch <= r_s1_batch;
      r_s2_sum   <= w_colsum;
    end
  end

  // S3: accumulate per candidate; batch-last column publishes the SAD vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sbv       <= 1'b0;
      r_sad_batch <= '0;
      r_s3_wl     <= 1'b0;
      r_s3_batch  <= '0;
      for (int k = 0; k < int'(PIXELS_IN_BATCH); k++) r_acc[k] <= '0;
    end else begin
      r_sbv <= 1'b0;
      if (w_start) begin
        for (int k = 0; k < int'(PIXELS_IN_BATCH); k++) r_acc[k] <= '0;
      end else if (r_s2_vld) begin
        if (r_s2_bl) begin
          for (int k = 0; k < int'(PIXELS_IN_BATCH); k++) begin
            r_sad_batch[k*int'(SAD_WIDTH) +: SAD_WIDTH] <= r_acc[k] + SAD_WIDTH'(r_s2_sum[k]);
            r_acc[k] <= '0;
          end
          r_sbv      <= 1'b1;
          r_s3_wl    <= r_s2_wl;
          r_s3_batch <= r_s2_batch;
        end else begin
          for (int k = 0; k < int'(PIXELS_IN_BATCH); k++)
            r_acc[k] <= r_acc[k] + SAD_WIDTH'(r_s2_sum[k]);
        end
      end
    end
  end
endmodule

// File: tb/tb_me_sad_search_engine.sv
// Self-checking bench for me_sad_search_engine: table of directed/random windows checked
// against a plain-arithmetic SAD model, plus reset-abort and ignored-input sequences.
module tb_me_sad_search_engine;
  localparam int PIB = 16, E = 8, BD = 8, NB = 4, SW = 14, IW = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  me_sad_search_engine_if bus ();
  me_sad_search_engine u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [7:0] cur_px [E][E];
  logic [7:0] ref_px [NB][E][E][PIB];   // [batch][column][row][lane]
  int exp_sad [NB][PIB];
  int exp_best, exp_idx;
  int total = 0, bad = 0;
  int cyc = 0;

  int acc_q[$], sbv_q[$], done_q[$], dsad_q[$], didx_q[$];
  logic [SW*PIB-1:0] sbv_val_q[$];

  typedef struct {
    int mode;      // 0 random, 1 single match, 2 max diff, 3 near, 4 ties
    int gap;       // idle cycles between columns, -1 random
    bit disturb;   // stray start / col_valid outside RUN
    bit keep;      // reuse previous window data
    int exp_best;  // -1: model only
    int exp_idx;
  } vec_t;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.col_valid && bus.col_ready) acc_q.push_back(cyc);
      if (bus.sad_batch_valid) begin
        sbv_q.push_back(cyc);
        sbv_val_q.push_back(bus.sad_batch);
      end
      if (bus.done) begin
        done_q.push_back(cyc);
        dsad_q.push_back(int'(bus.best_sad));
        didx_q.push_back(int'(bus.best_idx));
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_q.delete(); sbv_q.delete(); sbv_val_q.delete();
    done_q.delete(); dsad_q.delete(); didx_q.delete();
  endtask

  task automatic gen(input int mode);
    int v;
    for (int r = 0; r < E; r++)
      for (int c = 0; c < E; c++)
        cur_px[r][c] = (mode == 2) ? 8'd0 :
                       (mode == 1 || mode == 4) ? 8'($urandom_range(0, 254)) : 8'($urandom);
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < E; c++)
        for (int r = 0; r < E; r++)
          for (int k = 0; k < PIB; k++) begin
            case (mode)
              1: ref_px[b][c][r][k] = (b == 2 && k == 5) ? cur_px[r][c] : 8'(cur_px[r][c] + 1);
              2: ref_px[b][c][r][k] = 8'd255;
              3: begin
                v = int'(cur_px[r][c]) + int'($urandom_range(0, 6)) - 3;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                ref_px[b][c][r][k] = 8'(v);
              end
              4: ref_px[b][c][r][k] = ((b == 1 && (k == 9 || k == 4)) || (b == 3 && k == 2)) ?
                                      cur_px[r][c] : 8'(cur_px[r][c] + 1);
              default: ref_px[b][c][r][k] = 8'($urandom);
            endcase
          end
  endtask

  // Reference: full-block SAD per candidate, first strictly smaller candidate in index order wins.
  task automatic model();
    int s, d;
    exp_best = 1 << 30;
    exp_idx  = 0;
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < PIB; k++) begin
        s = 0;
        for (int r = 0; r < E; r++)
          for (int c = 0; c < E; c++) begin
            d = int'(ref_px[b][c][r][k]) - int'(cur_px[r][c]);
            s += (d < 0) ? -d : d;
          end
        exp_sad[b][k] = s;
        if (s < exp_best) begin
          exp_best = s;
          exp_idx  = b * PIB + k;
        end
      end
  endtask

  task automatic drive_start();
    for (int r = 0; r < E; r++)
      for (int c = 0; c < E; c++) bus.cur_block[(r*E+c)*BD +: BD] = cur_px[r][c];
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic feed_col(input int b, input int c, output bit ok);
    int n = 0;
    bit acc = 1'b0;
    for (int r = 0; r < E; r++)
      for (int k = 0; k < PIB; k++) bus.ref_col[(r*PIB+k)*BD +: BD] = ref_px[b][c][r][k];
    bus.col_valid = 1'b1;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = bus.col_ready;
      n++;
      @(posedge clk);
      #1;
    end
    bus.col_valid = 1'b0;
    ok = acc;
    if (!acc) chk("col_accept_timeout", 0, 1);
  endtask

  task automatic run_search(input vec_t v, input int tid);
    bit ok;
    int n, g, last;
    logic [SW*PIB-1:0] sv;
    if (!v.keep) gen(v.mode);
    model();
    clear_logs();
    if (v.disturb) begin
      bus.col_valid = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk($sformatf("t%0d_idle_col_ready", tid), int'(bus.col_ready), 0);
        step();
      end
      bus.col_valid = 1'b0;
    end
    drive_start();
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < E; c++) begin
        feed_col(b, c, ok);
        if (!ok) return;
        if (v.disturb && b == 0 && c == 5) begin
          bus.cur_block = {E*E*BD{1'b1}};
          bus.start = 1'b1;
          step();
          bus.start = 1'b0;
        end
        g = (v.gap < 0) ? int'($urandom_range(0, 2)) : v.gap;
        repeat (g) step();
      end
    n = 0;
    while (done_q.size() == 0 && n < 40) begin
      step();
      n++;
    end
    repeat (5) step();
    if (v.disturb) begin
      bus.col_valid = 1'b1;
      repeat (4) begin
        @(negedge clk);
        chk($sformatf("t%0d_post_col_ready", tid), int'(bus.col_ready), 0);
        step();
      end
      bus.col_valid = 1'b0;
      step();
    end
    chk($sformatf("t%0d_accepts", tid), acc_q.size(), NB*E);
    chk($sformatf("t%0d_sbv_pulses", tid), sbv_q.size(), NB);
    chk($sformatf("t%0d_done_pulses", tid), done_q.size(), 1);
    if (acc_q.size() != NB*E) return;
    last = acc_q[NB*E-1];
    for (int i = 0; i < NB && i < sbv_q.size(); i++) begin
      chk($sformatf("t%0d_sbv%0d_latency", tid, i), sbv_q[i] - acc_q[(i+1)*E-1], 3);
      sv = sbv_val_q[i];
      for (int k = 0; k < PIB; k++)
        chk($sformatf("t%0d_b%0d_lane%0d", tid, i, k), int'(sv[k*SW +: SW]), exp_sad[i][k]);
    end
    if (done_q.size() > 0) begin
      chk($sformatf("t%0d_done_latency", tid), done_q[0] - last, 4);
      chk($sformatf("t%0d_best_sad", tid), dsad_q[0], exp_best);
      chk($sformatf("t%0d_best_idx", tid), didx_q[0], exp_idx);
      if (v.exp_best >= 0) begin
        chk($sformatf("t%0d_best_sad_tbl", tid), dsad_q[0], v.exp_best);
        chk($sformatf("t%0d_best_idx_tbl", tid), didx_q[0], v.exp_idx);
      end
    end
    chk($sformatf("t%0d_best_sad_hold", tid), int'(bus.best_sad), exp_best);
    chk($sformatf("t%0d_best_idx_hold", tid), int'(bus.best_idx), exp_idx);
    chk($sformatf("t%0d_busy_idle", tid), int'(bus.busy), 0);
    sv = bus.sad_batch;
    chk($sformatf("t%0d_sad_hold", tid), int'(sv[(PIB-1)*SW +: SW]), exp_sad[NB-1][PIB-1]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_col_ready"}, int'(bus.col_ready), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_sbv"}, int'(bus.sad_batch_valid), 0);
    chk({tag, "_sad_batch_nz"}, int'(|bus.sad_batch), 0);
    chk({tag, "_best_sad"}, int'(bus.best_sad), 0);
    chk({tag, "_best_idx"}, int'(bus.best_idx), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    vec_t v;
    bit ok;
    vecs[0] = '{mode: 1, gap:  0, disturb: 1'b0, keep: 1'b0, exp_best: 0,     exp_idx: 37};
    vecs[1] = '{mode: 2, gap:  0, disturb: 1'b0, keep: 1'b0, exp_best: 16320, exp_idx: 0};
    vecs[2] = '{mode: 0, gap:  0, disturb: 1'b0, keep: 1'b0, exp_best: -1,    exp_idx: 0};
    vecs[3] = '{mode: 0, gap:  1, disturb: 1'b0, keep: 1'b1, exp_best: -1,    exp_idx: 0};
    vecs[4] = '{mode: 4, gap:  0, disturb: 1'b0, keep: 1'b0, exp_best: 0,     exp_idx: 20};
    vecs[5] = '{mode: 0, gap:  0, disturb: 1'b1, keep: 1'b0, exp_best: -1,    exp_idx: 0};
    vecs[6] = '{mode: 3, gap:  2, disturb: 1'b0, keep: 1'b0, exp_best: -1,    exp_idx: 0};
    vecs[7] = '{mode: 3, gap: -1, disturb: 1'b0, keep: 1'b0, exp_best: -1,    exp_idx: 0};

    bus.start = 1'b0;
    bus.col_valid = 1'b0;
    bus.cur_block = '0;
    bus.ref_col = '0;
    #2 rst = 1'b1;
    #2 chk_all_zero("reset");
    repeat (3) step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_search(vecs[i], i);

    // Abort in batch 1, then a fresh window must be unaffected.
    gen(0);
    clear_logs();
    drive_start();
    for (int c = 0; c < E + 4; c++) feed_col(c / E, c % E, ok);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_all_zero("abort");
    repeat (2) step();
    rst = 1'b0;
    step();
    v = '{mode: 0, gap: 0, disturb: 1'b0, keep: 1'b0, exp_best: -1, exp_idx: 0};
    run_search(v, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
